// File: rtl/dac_spi_writer.sv
// SPI write master for the LTC2624 quad 12-bit DAC: latches up to four signed
// samples and sends one 32-bit write-and-update frame per enabled channel, A to D.
module dac_spi_writer #(
    parameter int          M       = 14,
    parameter int          CLK_DIV = 4,
    parameter logic [3:0]  CMD     = 4'b0011
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [M-1:0] ch_a,
    input  logic signed [M-1:0] ch_b,
    input  logic signed [M-1:0] ch_c,
    input  logic signed [M-1:0] ch_d,
    input  logic [3:0]          ch_en,
    output logic                busy,
    output logic                done,
    output logic                SPI_MOSI,
    output logic                SPI_SCK,
    output logic                DAC_CS,
    output logic                DAC_CLR
);

    localparam int CW = $clog2(2 * CLK_DIV + 1);

    typedef enum logic [2:0] {IDLE, NEXT, SHIFT, GAP, FIN, DONE} state_t;

    state_t         state_reg;
    logic [3:0]     pend_reg;
    logic [11:0]    code_reg [4];
    logic [31:0]    shreg;
    logic [4:0]     bit_reg;
    logic [CW-1:0]  cnt_reg;
    logic           half_reg;

    logic [M-1:0]   ch_in   [4];
    logic [11:0]    code_in [4];

    assign ch_in[0] = ch_a;
    assign ch_in[1] = ch_b;
    assign ch_in[2] = ch_c;
    assign ch_in[3] = ch_d;

    // Offset binary: keep the top 12 bits and flip the sign bit.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_conv
            assign code_in[gi] = {~ch_in[gi][M-1], ch_in[gi][M-2:M-12]};
            if (M > 12) begin : g_low
                logic unused_low;
                assign unused_low = ^ch_in[gi][M-13:0];
            end
        end
    endgenerate

    logic        sel_valid;
    logic [1:0]  sel_idx;
    logic [31:0] sel_frame;

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pend_reg[i]) begin
                sel_valid = 1'b1;
                sel_idx   = 2'(i);
            end
        end
        sel_frame = {8'h00, CMD, 2'b00, sel_idx, code_reg[sel_idx], 4'h0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            pend_reg  <= 4'd0;
            for (int i = 0; i < 4; i++) code_reg[i] <= 12'd0;
            shreg     <= 32'd0;
            bit_reg   <= 5'd0;
            cnt_reg   <= '0;
            half_reg  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            SPI_MOSI  <= 1'b0;
            SPI_SCK   <= 1'b0;
            DAC_CS    <= 1'b1;
            DAC_CLR   <= 1'b0;
        end else begin
            DAC_CLR <= 1'b1;
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < 4; i++) code_reg[i] <= code_in[i];
                        pend_reg  <= ch_en;
                        state_reg <= NEXT;
                    end
                end
                NEXT: begin
                    busy <= 1'b1;
                    if (sel_valid) begin
                        pend_reg[sel_idx] <= 1'b0;
                        // shreg holds the frame pre-shifted so bit 31 is always the next bit
                        shreg     <= {sel_frame[30:0], 1'b0};
                        SPI_MOSI  <= sel_frame[31];
                        SPI_SCK   <= 1'b0;
                        DAC_CS    <= 1'b0;
                        bit_reg   <= 5'd0;
                        cnt_reg   <= '0;
                        half_reg  <= 1'b0;
                        state_reg <= SHIFT;
                    end else begin
                        state_reg <= FIN;
                    end
                end
                SHIFT: begin
                    if (cnt_reg == CW'(CLK_DIV - 1)) begin
                        cnt_reg <= '0;
                        if (!half_reg) begin
                            SPI_SCK  <= 1'b1;
                            half_reg <= 1'b1;
                        end else begin
                            SPI_SCK  <= 1'b0;
                            half_reg <= 1'b0;
                            if (bit_reg == 5'd31) begin
                                DAC_CS    <= 1'b1;
                                SPI_MOSI  <= 1'b0;
                                state_reg <= GAP;
                            end else begin
                                bit_reg  <= bit_reg + 5'd1;
                                SPI_MOSI <= shreg[31];
                                shreg    <= {shreg[30:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                GAP: begin
                    // The NEXT cycle supplies the last of the 2*CLK_DIV CS-high cycles.
                    if (cnt_reg == CW'(2 * CLK_DIV - 2)) begin
                        cnt_reg   <= '0;
                        state_reg <= NEXT;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                FIN: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= DONE;
                end
                DONE: begin
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_writer.sv
// Bench for dac_spi_writer: directed vector table, randomized sequences against
// an arithmetic frame model, busy-restart and mid-frame reset sequences.
module tb_dac_spi_writer;
    localparam int M  = 14;
    localparam int CD = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic signed [M-1:0] ch_a = '0, ch_b = '0, ch_c = '0, ch_d = '0;
    logic [3:0]          ch_en = 4'd0;
    logic                busy, done, SPI_MOSI, SPI_SCK, DAC_CS, DAC_CLR;

    dac_spi_writer #(.M(M), .CLK_DIV(CD), .CMD(4'b0011)) dut (
        .clk(clk), .rst(rst), .start(start),
        .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c), .ch_d(ch_d), .ch_en(ch_en),
        .busy(busy), .done(done), .SPI_MOSI(SPI_MOSI), .SPI_SCK(SPI_SCK),
        .DAC_CS(DAC_CS), .DAC_CLR(DAC_CLR)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // SPI capture: bits on SCK rising edges while CS low, frame stored on a
    // CS rising edge only if 32 bits were seen and reset is not asserted.
    logic [31:0] sh = 32'd0;
    int          nbits = 0;
    int          rises = 0;
    logic [31:0] cap_q [$];

    always @(posedge SPI_SCK) begin
        rises++;
        if (!DAC_CS) begin
            sh = {sh[30:0], SPI_MOSI};
            nbits++;
        end
    end
    always @(negedge DAC_CS) nbits = 0;
    always @(posedge DAC_CS) if (rst && nbits == 32) cap_q.push_back(sh);

    typedef struct {
        int              a, b, c, d;
        logic [3:0]      en;
        int              nf;
        logic [3:0][31:0] f;
    } vec_t;

    function automatic vec_t mkvec(int a, int b, int c, int d, logic [3:0] en, int nf,
                                   logic [31:0] f0, logic [31:0] f1,
                                   logic [31:0] f2, logic [31:0] f3);
        vec_t v;
        v.a = a; v.b = b; v.c = c; v.d = d; v.en = en; v.nf = nf;
        v.f[0] = f0; v.f[1] = f1; v.f[2] = f2; v.f[3] = f3;
        return v;
    endfunction

    // Reference: offset-binary code = (x + 2^(M-1)) / 2^(M-12); frames go out in address order.
    function automatic logic [31:0] model_frame(int addr, int x);
        int code;
        code = (x + (1 << (M - 1))) / (1 << (M - 12));
        return 32'((3 << 20) + (addr << 16) + (code << 4));
    endfunction

    function automatic vec_t model_vec(int a, int b, int c, int d, logic [3:0] en);
        vec_t v;
        int   s [4];
        s[0] = a; s[1] = b; s[2] = c; s[3] = d;
        v.a = a; v.b = b; v.c = c; v.d = d; v.en = en; v.nf = 0; v.f = '0;
        for (int i = 0; i < 4; i++)
            if (en[i]) begin
                v.f[v.nf] = model_frame(i, s[i]);
                v.nf++;
            end
        return v;
    endfunction

    task automatic run_seq(input vec_t v, input bit disturb, input string tag);
        int k, cs_low, done_k, r0;
        cap_q.delete();
        r0 = rises;
        @(negedge clk);
        ch_a = M'(v.a); ch_b = M'(v.b); ch_c = M'(v.c); ch_d = M'(v.d);
        ch_en = v.en; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0; cs_low = 0; done_k = -1;
        chk({tag, " busy_at_T"}, busy, 0);
        while (k < 1200 && done_k < 0) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                chk({tag, " busy_rise"}, busy, 1);
                chk({tag, " cs_first"}, DAC_CS, (v.nf > 0) ? 0 : 1);
            end
            if (!DAC_CS) cs_low++;
            if (disturb && k == 100) begin
                start = 1'b1;
                ch_a = M'($urandom); ch_b = M'($urandom); ch_c = M'($urandom); ch_d = M'($urandom);
                ch_en = ~v.en;
            end
            if (disturb && k == 101) start = 1'b0;
            if (done) begin
                done_k = k;
                chk({tag, " busy_at_done"}, busy, 0);
            end
        end
        chk({tag, " done_cycle"}, done_k, 264 * v.nf + 2);
        @(negedge clk);
        chk({tag, " done_pulse_width"}, done, 0);
        chk({tag, " cs_low_cycles"}, cs_low, 256 * v.nf);
        chk({tag, " sck_rises"}, rises - r0, 32 * v.nf);
        chk({tag, " frame_count"}, cap_q.size(), v.nf);
        for (int i = 0; i < v.nf && i < cap_q.size(); i++)
            chk($sformatf("%s frame%0d", tag, i), cap_q[i], v.f[i]);
        $display("seq %s en=%b frames=%0d done_at=%0d", tag, v.en, cap_q.size(), done_k);
    endtask

    vec_t tbl [4];

    initial begin
        tbl[0] = mkvec(0, 0, 0, 0, 4'b0001, 1, 32'h0030_8000, 0, 0, 0);
        tbl[1] = mkvec(-8192, 4096, 8191, -1, 4'hF, 4,
                       32'h0030_0000, 32'h0031_C000, 32'h0032_FFF0, 32'h0033_7FF0);
        tbl[2] = mkvec(100, 4096, -300, -1, 4'b1010, 2, 32'h0031_C000, 32'h0033_7FF0, 0, 0);
        tbl[3] = mkvec(5, 6, 7, 8, 4'b0000, 0, 0, 0, 0, 0);

        // Power-on reset values and DAC_CLR release.
        repeat (3) @(negedge clk);
        chk("rst DAC_CS", DAC_CS, 1);
        chk("rst SPI_SCK", SPI_SCK, 0);
        chk("rst SPI_MOSI", SPI_MOSI, 0);
        chk("rst DAC_CLR", DAC_CLR, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("clr_release", DAC_CLR, 1);

        for (int i = 0; i < 4; i++) run_seq(tbl[i], 1'b0, $sformatf("tbl%0d", i));

        // Restart attempt and input changes while busy must be ignored.
        run_seq(tbl[1], 1'b1, "busy_restart");

        for (int i = 0; i < 6; i++) begin
            int s [4];
            for (int j = 0; j < 4; j++) s[j] = int'($urandom_range(0, (1 << M) - 1)) - (1 << (M - 1));
            run_seq(model_vec(s[0], s[1], s[2], s[3], 4'($urandom_range(0, 15))), i[0],
                    $sformatf("rand%0d", i));
        end

        // Reset during bit 10 of frame B.
        begin
            int dn;
            dn = 0;
            cap_q.delete();
            @(negedge clk);
            ch_a = M'(tbl[1].a); ch_b = M'(tbl[1].b); ch_c = M'(tbl[1].c); ch_d = M'(tbl[1].d);
            ch_en = 4'hF; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (349) begin
                @(negedge clk);
                if (done) dn++;
            end
            chk("midrst cs_before", DAC_CS, 0);
            chk("midrst partial_bits", nbits, 11);
            rst = 1'b0;
            #1;
            chk("midrst DAC_CS", DAC_CS, 1);
            chk("midrst SPI_SCK", SPI_SCK, 0);
            chk("midrst busy", busy, 0);
            chk("midrst DAC_CLR", DAC_CLR, 0);
            repeat (3) begin
                @(negedge clk);
                if (done) dn++;
            end
            rst = 1'b1;
            repeat (4) begin
                @(negedge clk);
                if (done) dn++;
            end
            chk("midrst no_done", dn, 0);
            chk("midrst frames_kept", cap_q.size(), 1);
            chk("midrst DAC_CLR_after", DAC_CLR, 1);
            chk("midrst state_idle_busy", busy, 0);
            $display("seq midrst frames=%0d done_pulses=%0d", cap_q.size(), dn);
        end
        run_seq(tbl[1], 1'b0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
